// File: rtl/cache_tag_lookup_if.sv
// rtl/cache_tag_lookup_if.sv - request/response bundle for the tag-lookup stage
interface cache_tag_lookup_if #(
    parameter int ADDR_W   = 12,
    parameter int OFFSET_W = 4,
    parameter int WAYS     = 4,
    parameter int DATA_W   = 16
);
    localparam int WAY_W = $clog2(WAYS);
    localparam int BLK_W = ADDR_W - OFFSET_W;

    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] req_addr;
    logic              req_write;
    logic [DATA_W-1:0] req_wdata;

    logic              resp_valid;
    logic              resp_ready;
    logic              resp_hit;
    logic [WAY_W-1:0]  resp_way;
    logic              resp_victim_dirty;
    logic [BLK_W-1:0]  resp_victim_blk;
    logic [ADDR_W-1:0] resp_addr;
    logic              resp_write;
    logic [DATA_W-1:0] resp_wdata;

    modport master (
        output req_valid, req_addr, req_write, req_wdata, resp_ready,
        input  req_ready, resp_valid, resp_hit, resp_way, resp_victim_dirty,
               resp_victim_blk, resp_addr, resp_write, resp_wdata
    );

    modport slave (
        input  req_valid, req_addr, req_write, req_wdata, resp_ready,
        output req_ready, resp_valid, resp_hit, resp_way, resp_victim_dirty,
               resp_victim_blk, resp_addr, resp_write, resp_wdata
    );
endinterface

// File: rtl/cache_tag_lookup.sv
// rtl/cache_tag_lookup.sv - set-associative tag compare, victim selection and LRU update
module cache_tag_lookup #(
    parameter int ADDR_W   = 12,
    parameter int OFFSET_W = 4,
    parameter int SET_W    = 3,
    parameter int WAYS     = 4,
    parameter int DATA_W   = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    cache_tag_lookup_if.slave  bus
);
    localparam int SETS  = 1 << SET_W;
    localparam int WAY_W = $clog2(WAYS);
    localparam int BLK_W = ADDR_W - OFFSET_W;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CMP  = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [SETS-1:0][WAYS-1:0]             valid_q, valid_d;
    logic [SETS-1:0][WAYS-1:0]             dirty_q, dirty_d;
    logic [SETS-1:0][WAYS-1:0][BLK_W-1:0]  blk_q, blk_d;
    logic [SETS-1:0][WAYS-1:0][WAY_W-1:0]  age_q, age_d;

    logic              hit_q, hit_d;
    logic [WAY_W-1:0]  way_q, way_d;
    logic              vdirty_q, vdirty_d;
    logic [BLK_W-1:0]  vblk_q, vblk_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              write_q, write_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;

    logic [SET_W-1:0]  set_idx;
    logic [BLK_W-1:0]  cur_blk;
    logic              hit;
    logic [WAY_W-1:0]  hit_way;
    logic              found_inv;
    logic [WAY_W-1:0]  inv_way;
    logic [WAY_W-1:0]  lru_way;
    logic [WAY_W-1:0]  victim_way;
    logic [WAY_W-1:0]  acc_way;

    always_comb begin
        state_d  = state_q;
        valid_d  = valid_q;
        dirty_d  = dirty_q;
        blk_d    = blk_q;
        age_d    = age_q;
        hit_d    = hit_q;
        way_d    = way_q;
        vdirty_d = vdirty_q;
        vblk_d   = vblk_q;
        addr_d   = addr_q;
        write_d  = write_q;
        wdata_d  = wdata_q;

        set_idx   = addr_q[OFFSET_W +: SET_W];
        cur_blk   = addr_q[ADDR_W-1:OFFSET_W];
        hit       = 1'b0;
        hit_way   = '0;
        found_inv = 1'b0;
        inv_way   = '0;
        lru_way   = '0;

        for (int i = 0; i < WAYS; i++) begin
            if (valid_q[set_idx][i] && blk_q[set_idx][i] == cur_blk && !hit) begin
                hit     = 1'b1;
                hit_way = WAY_W'(i);
            end
            if (!valid_q[set_idx][i] && !found_inv) begin
                found_inv = 1'b1;
                inv_way   = WAY_W'(i);
            end
            if (age_q[set_idx][i] == WAY_W'(WAYS - 1)) begin
                lru_way = WAY_W'(i);
            end
        end
        // Empty ways are always filled before anything valid is evicted.
        victim_way = found_inv ? inv_way : lru_way;
        acc_way    = hit ? hit_way : victim_way;

        unique case (state_q)
            S_IDLE: begin
                if (bus.req_valid) begin
                    addr_d  = bus.req_addr;
                    write_d = bus.req_write;
                    wdata_d = bus.req_wdata;
                    state_d = S_CMP;
                end
            end
            S_CMP: begin
                hit_d = hit;
                way_d = acc_way;
                if (hit) begin
                    vdirty_d = 1'b0;
                    vblk_d   = '0;
                    if (write_q) begin
                        dirty_d[set_idx][hit_way] = 1'b1;
                    end
                end else begin
                    // Victim state is captured here, before the new tag overwrites it.
                    vdirty_d = valid_q[set_idx][victim_way] & dirty_q[set_idx][victim_way];
                    vblk_d   = blk_q[set_idx][victim_way];
                    valid_d[set_idx][victim_way] = 1'b1;
                    dirty_d[set_idx][victim_way] = write_q;
                    blk_d[set_idx][victim_way]   = cur_blk;
                end
                for (int i = 0; i < WAYS; i++) begin
                    if (WAY_W'(i) == acc_way) begin
                        age_d[set_idx][i] = '0;
                    end else if (age_q[set_idx][i] < age_q[set_idx][acc_way]) begin
                        age_d[set_idx][i] = age_q[set_idx][i] + WAY_W'(1);
                    end
                end
                state_d = S_RESP;
            end
            S_RESP: begin
                if (bus.resp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            valid_q  <= '0;
            dirty_q  <= '0;
            blk_q    <= '0;
            for (int s = 0; s < SETS; s++) begin
                for (int w = 0; w < WAYS; w++) begin
                    age_q[s][w] <= WAY_W'(w);
                end
            end
            hit_q    <= 1'b0;
            way_q    <= '0;
            vdirty_q <= 1'b0;
            vblk_q   <= '0;
            addr_q   <= '0;
            write_q  <= 1'b0;
            wdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            valid_q  <= valid_d;
            dirty_q  <= dirty_d;
            blk_q    <= blk_d;
            age_q    <= age_d;
            hit_q    <= hit_d;
            way_q    <= way_d;
            vdirty_q <= vdirty_d;
            vblk_q   <= vblk_d;
            addr_q   <= addr_d;
            write_q  <= write_d;
            wdata_q  <= wdata_d;
        end
    end

    assign bus.req_ready         = (state_q == S_IDLE);
    assign bus.resp_valid        = (state_q == S_RESP);
    assign bus.resp_hit          = hit_q;
    assign bus.resp_way          = way_q;
    assign bus.resp_victim_dirty = vdirty_q;
    assign bus.resp_victim_blk   = vblk_q;
    assign bus.resp_addr         = addr_q;
    assign bus.resp_write        = write_q;
    assign bus.resp_wdata        = wdata_q;
endmodule
